// File: rtl/ps2_key_decoder_if.sv
// Keyboard decoder bus: scan-byte strobe in, buffered ASCII stream and status out.
interface ps2_key_decoder_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic [7:0]       scan_code;
  logic             scan_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             shift_on;
  logic             caps_on;
  logic             overflow;
  logic [CNT_W-1:0] key_count;

  modport master (
    output scan_code, scan_valid, out_ready,
    input  out_data, out_valid, shift_on, caps_on, overflow, key_count
  );

  modport slave (
    input  scan_code, scan_valid, out_ready,
    output out_data, out_valid, shift_on, caps_on, overflow, key_count
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code parser with shift/caps tracking, ASCII translation,
// repeat filtering, an output FIFO and a keystroke counter.
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CNT_W         = 8,
  parameter bit          FILTER_REPEAT = 1'b1
) (
  input logic              clk,
  input logic              clrn,
  ps2_key_decoder_if.slave bus
);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_make, w_break;
  logic [7:0]       r_held;
  logic             r_lshift, r_rshift, r_caps, r_overflow;
  logic [CNT_W-1:0] r_key_count;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic [7:0]       w_char;
  logic             w_shift, w_upper, w_push_req, w_push, w_pop, w_full;

  // Parser: F0/E0 prefixes steer the following byte
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    if (bus.scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.scan_code == 8'hF0)      w_state_nxt = ST_BRK;
          else if (bus.scan_code == 8'hE0) w_state_nxt = ST_EXT;
          else                             w_make      = 1'b1;
        end
        ST_BRK: begin
          w_break     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXT:  w_state_nxt = (bus.scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_shift = r_lshift | r_rshift;
  assign w_upper = w_shift ^ r_caps;

  // Translation; letters are listed uppercase and folded afterwards, 0x00 = unmapped
  always_comb begin
    w_char = 8'h00;
    case (bus.scan_code)
      8'h1C: w_char = "A";  8'h32: w_char = "B";  8'h21: w_char = "C";
      8'h23: w_char = "D";  8'h24: w_char = "E";  8'h2B: w_char = "F";
      8'h34: w_char = "G";  8'h33: w_char = "H";  8'h43: w_char = "I";
      8'h3B: w_char = "J";  8'h42: w_char = "K";  8'h4B: w_char = "L";
      8'h3A: w_char = "M";  8'h31: w_char = "N";  8'h44: w_char = "O";
      8'h4D: w_char = "P";  8'h15: w_char = "Q";  8'h2D: w_char = "R";
      8'h1B: w_char = "S";  8'h2C: w_char = "T";  8'h3C: w_char = "U";
      8'h2A: w_char = "V";  8'h1D: w_char = "W";  8'h22: w_char = "X";
      8'h35: w_char = "Y";  8'h1A: w_char = "Z";
      8'h45: w_char = w_shift ? ")" : "0";
      8'h16: w_char = w_shift ? "!" : "1";
      8'h1E: w_char = w_shift ? "@" : "2";
      8'h26: w_char = w_shift ? "#" : "3";
      8'h25: w_char = w_shift ? "$" : "4";
      8'h2E: w_char = w_shift ? "%" : "5";
      8'h36: w_char = w_shift ? "^" : "6";
      8'h3D: w_char = w_shift ? "&" : "7";
      8'h3E: w_char = w_shift ? "*" : "8";
      8'h46: w_char = w_shift ? "(" : "9";
      8'h41: w_char = w_shift ? "<" : ",";
      8'h49: w_char = w_shift ? ">" : ".";
      8'h4A: w_char = w_shift ? "?" : "/";
      8'h4C: w_char = w_shift ? ":" : ";";
      8'h52: w_char = w_shift ? 8'h22 : 8'h27;
      8'h54: w_char = w_shift ? "{" : "[";
      8'h5B: w_char = w_shift ? "}" : "]";
      8'h5D: w_char = w_shift ? "|" : 8'h5C;
      8'h0E: w_char = w_shift ? "~" : 8'h60;
      8'h4E: w_char = w_shift ? "_" : "-";
      8'h55: w_char = w_shift ? "+" : "=";
      8'h29: w_char = 8'h20;
      8'h5A: w_char = 8'h0D;
      8'h66: w_char = 8'h08;
      default: w_char = 8'h00;
    endcase
    if (!w_upper && w_char >= "A" && w_char <= "Z") w_char = w_char | 8'h20;
  end

  assign w_full     = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_pop      = (r_count != '0) && bus.out_ready;
  assign w_push_req = w_make && (w_char != 8'h00) &&
                      !(FILTER_REPEAT && (bus.scan_code == r_held));
  assign w_push     = w_push_req && (!w_full || w_pop);

  // Keyboard state: modifiers, caps toggle, held key, drop flag, counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_held      <= 8'h00;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_caps      <= 1'b0;
      r_overflow  <= 1'b0;
      r_key_count <= '0;
    end else begin
      if (w_make) begin
        if (bus.scan_code == 8'h12)      r_lshift <= 1'b1;
        else if (bus.scan_code == 8'h59) r_rshift <= 1'b1;
        else begin
          r_held <= bus.scan_code;
          if (bus.scan_code == 8'h58 && r_held != 8'h58) r_caps <= ~r_caps;
        end
      end
      if (w_break) begin
        if (bus.scan_code == 8'h12) r_lshift <= 1'b0;
        if (bus.scan_code == 8'h59) r_rshift <= 1'b0;
        if (bus.scan_code == r_held) r_held <= 8'h00;
      end
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      if (w_push) r_key_count <= r_key_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - OCC_W'(1);
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_char;
  end

  assign bus.out_data  = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.out_valid = (r_count != '0);
  assign bus.shift_on  = w_shift;
  assign bus.caps_on   = r_caps;
  assign bus.overflow  = r_overflow;
  assign bus.key_count = r_key_count;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus randomized bytes checked
// against a keyboard model; dut A is depth 4 with repeat filter, dut B depth 8 without.
module tb_ps2_key_decoder;
  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       out_ready = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  ps2_key_decoder_if #(.CNT_W(8)) ifa ();
  ps2_key_decoder_if #(.CNT_W(8)) ifb ();
  assign ifa.scan_code = scan_code;  assign ifb.scan_code = scan_code;
  assign ifa.scan_valid = scan_valid; assign ifb.scan_valid = scan_valid;
  assign ifa.out_ready = out_ready;  assign ifb.out_ready = out_ready;

  ps2_key_decoder #(.FIFO_DEPTH(4), .CNT_W(8), .FILTER_REPEAT(1'b1)) u_dut_a (
    .clk(clk), .clrn(clrn), .bus(ifa));
  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .FILTER_REPEAT(1'b0)) u_dut_b (
    .clk(clk), .clrn(clrn), .bus(ifb));

  // Keyboard model: prefix flags, key state, one character queue per dut
  bit         m_e0, m_f0, m_ls, m_rs, m_caps;
  logic [7:0] m_held;
  logic [7:0] mq [2][$];
  bit         m_ovf [2];
  logic [7:0] m_cnt [2];
  int         m_depth [2] = '{4, 8};

  logic [7:0] lt [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                          8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                          8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dg [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] pc [11] = '{8'h41,8'h49,8'h4A,8'h4C,8'h52,8'h54,8'h5B,8'h5D,8'h0E,8'h4E,8'h55};
  string dsh = ")!@#$%^&*(";
  string pun = ",./;'[]\\`-=";
  string psh = "<>?:\"{}|~_+";

  function automatic int model_char(input logic [7:0] c, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++) if (lt[i] == c) return ((sh ^ cp) ? 65 : 97) + i;
    for (int i = 0; i < 10; i++) if (dg[i] == c) return sh ? int'(dsh[i]) : 48 + i;
    for (int i = 0; i < 11; i++) if (pc[i] == c) return sh ? int'(psh[i]) : int'(pun[i]);
    if (c == 8'h29) return 32;
    if (c == 8'h5A) return 13;
    if (c == 8'h66) return 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_e0 = 0; m_f0 = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_held = 8'h00;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete(); m_ovf[k] = 0; m_cnt[k] = 8'h00;
    end
  endtask

  task automatic model_step();
    int ch = -1;
    bit rep = 0, brk, ext;
    if (!clrn) begin model_reset(); return; end
    if (scan_valid) begin
      if (!m_f0 && scan_code == 8'hF0) m_f0 = 1;
      else if (!m_e0 && !m_f0 && scan_code == 8'hE0) m_e0 = 1;
      else begin
        brk = m_f0; ext = m_e0; m_e0 = 0; m_f0 = 0;
        if (!ext && brk) begin
          if (scan_code == 8'h12) m_ls = 0;
          if (scan_code == 8'h59) m_rs = 0;
          if (scan_code == m_held) m_held = 8'h00;
        end else if (!ext) begin
          ch  = model_char(scan_code, m_ls | m_rs, m_caps);
          rep = (scan_code == m_held);
          if (scan_code == 8'h12) m_ls = 1;
          else if (scan_code == 8'h59) m_rs = 1;
          else begin
            if (scan_code == 8'h58 && !rep) m_caps = !m_caps;
            m_held = scan_code;
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (mq[k].size() != 0 && out_ready) void'(mq[k].pop_front());
      if (ch >= 0 && !(k == 0 && rep)) begin
        if (mq[k].size() < m_depth[k]) begin
          mq[k].push_back(8'(ch)); m_cnt[k] = m_cnt[k] + 8'd1;
        end else m_ovf[k] = 1;
      end
    end
  endtask

  // One clock: inputs applied at negedge, model stepped on the same posedge
  task automatic tick(input bit v, input logic [7:0] c);
    scan_valid = v; scan_code = c;
    @(posedge clk); model_step();
    @(negedge clk); scan_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    tick(1'b1, c);
  endtask

  task automatic pop1();
    out_ready = 1'b1; tick(1'b0, 8'h00); out_ready = 1'b0;
  endtask

  task automatic do_reset();
    out_ready = 1'b0; clrn = 1'b0; model_reset();
    tick(1'b0, 8'h00); tick(1'b0, 8'h00);
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    send(8'h12); send(8'h58); send(8'h1C);
    clrn = 1'b0; #1;
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.out_data !== 8'h00) $display("FAIL rst_data got %h exp 00", ifa.out_data); else n_pass++;
    n_checks++; if (ifa.shift_on !== 1'b0) $display("FAIL rst_shift got %b exp 0", ifa.shift_on); else n_pass++;
    n_checks++; if (ifa.caps_on !== 1'b0) $display("FAIL rst_caps got %b exp 0", ifa.caps_on); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ifa.overflow); else n_pass++;
    n_checks++; if (ifa.key_count !== 8'd0) $display("FAIL rst_count got %0d exp 0", ifa.key_count); else n_pass++;
    @(negedge clk); do_reset();
  endtask

  task automatic test_letter();
    do_reset();
    send(8'h1C);
    n_checks++; if (ifa.out_valid !== 1'b1) $display("FAIL letter_valid got %b exp 1", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.out_data !== 8'h61) $display("FAIL letter_data got %h exp 61", ifa.out_data); else n_pass++;
    send(8'hF0); send(8'h1C);
    n_checks++; if (ifa.key_count !== 8'd1) $display("FAIL letter_count got %0d exp 1", ifa.key_count); else n_pass++;
    pop1();
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL letter_empty got %b exp 0", ifa.out_valid); else n_pass++;
    send(8'h1C);
    n_checks++; if (ifa.key_count !== 8'd2) $display("FAIL letter_held_clear got %0d exp 2", ifa.key_count); else n_pass++;
  endtask

  task automatic test_shift();
    do_reset();
    send(8'h12);
    n_checks++; if (ifa.shift_on !== 1'b1) $display("FAIL shift_on got %b exp 1", ifa.shift_on); else n_pass++;
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    n_checks++; if (ifa.shift_on !== 1'b0) $display("FAIL shift_off got %b exp 0", ifa.shift_on); else n_pass++;
    send(8'h1C);
    n_checks++; if (ifa.out_data !== 8'h41) $display("FAIL shift_first got %h exp 41", ifa.out_data); else n_pass++;
    pop1();
    n_checks++; if (ifa.out_data !== 8'h61) $display("FAIL shift_second got %h exp 61", ifa.out_data); else n_pass++;
    send(8'h59); send(8'h16);
    n_checks++; if (ifb.key_count !== 8'd3) $display("FAIL shift_rcount got %0d exp 3", ifb.key_count); else n_pass++;
  endtask

  task automatic test_caps();
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58);
    n_checks++; if (ifa.caps_on !== 1'b1) $display("FAIL caps_on got %b exp 1", ifa.caps_on); else n_pass++;
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h16); send(8'hF0); send(8'h16);
    n_checks++; if (ifa.out_data !== 8'h41) $display("FAIL caps_letter got %h exp 41", ifa.out_data); else n_pass++;
    pop1();
    n_checks++; if (ifa.out_data !== 8'h31) $display("FAIL caps_digit got %h exp 31", ifa.out_data); else n_pass++;
    pop1();
    send(8'h58); send(8'hF0); send(8'h58);
    n_checks++; if (ifa.caps_on !== 1'b0) $display("FAIL caps_off got %b exp 0", ifa.caps_on); else n_pass++;
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    n_checks++; if (ifa.caps_on !== 1'b1) $display("FAIL caps_repeat got %b exp 1", ifa.caps_on); else n_pass++;
  endtask

  task automatic test_repeat();
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    n_checks++; if (ifa.key_count !== 8'd2) $display("FAIL repeat_filter got %0d exp 2", ifa.key_count); else n_pass++;
    n_checks++; if (ifb.key_count !== 8'd4) $display("FAIL repeat_nofilter got %0d exp 4", ifb.key_count); else n_pass++;
  endtask

  task automatic test_extended();
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'hE0); send(8'h12);
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL ext_valid got %b exp 0", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.shift_on !== 1'b0) $display("FAIL ext_shift got %b exp 0", ifa.shift_on); else n_pass++;
    send(8'h1C);
    n_checks++; if (ifa.out_data !== 8'h61) $display("FAIL ext_final got %h exp 61", ifa.out_data); else n_pass++;
  endtask

  task automatic test_reset_midseq();
    do_reset();
    send(8'hF0);
    clrn = 1'b0; model_reset(); #2; clrn = 1'b1;
    @(negedge clk);
    send(8'h1C);
    n_checks++; if (ifa.out_data !== 8'h61) $display("FAIL midrst_data got %h exp 61", ifa.out_data); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] keys [9] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43};
    int n = 0;
    do_reset();
    foreach (keys[i]) begin send(keys[i]); send(8'hF0); send(keys[i]); end
    n_checks++; if (ifa.key_count !== 8'd4) $display("FAIL ovf_count got %0d exp 4", ifa.key_count); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", ifa.overflow); else n_pass++;
    n_checks++; if (ifb.key_count !== 8'd8) $display("FAIL ovf_count_b got %0d exp 8", ifb.key_count); else n_pass++;
    out_ready = 1'b1; send(8'h3B); out_ready = 1'b0;
    n_checks++; if (ifa.key_count !== 8'd5) $display("FAIL ovf_pushpop got %0d exp 5", ifa.key_count); else n_pass++;
    n_checks++; if (ifa.out_data !== 8'h62) $display("FAIL ovf_head got %h exp 62", ifa.out_data); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (!ifa.out_valid) break;
      n++; pop1();
    end
    n_checks++; if (n !== 4) $display("FAIL ovf_occupancy got %0d exp 4", n); else n_pass++;
  endtask

  task automatic test_random();
    logic [19:0] exp_v;
    logic [7:0]  hd, c;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: c = lt[$urandom_range(0, 25)];
        3:       c = dg[$urandom_range(0, 9)];
        4:       c = pc[$urandom_range(0, 10)];
        5:       c = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h5A;
        6:       c = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        7:       c = 8'h58;
        8:       c = 8'hF0;
        default: c = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'($urandom_range(0, 255));
      endcase
      out_ready = ($urandom_range(0, 2) == 0);
      tick($urandom_range(0, 9) < 6, c);
      hd = (mq[0].size() != 0) ? mq[0][0] : 8'h00;
      exp_v = {mq[0].size() != 0, hd, m_ls | m_rs, m_caps, m_ovf[0], m_cnt[0]};
      n_checks++;
      if ({ifa.out_valid, ifa.out_data, ifa.shift_on, ifa.caps_on, ifa.overflow, ifa.key_count} !== exp_v)
        $display("FAIL rand_a cyc %0d got %h exp %h", cyc,
          {ifa.out_valid, ifa.out_data, ifa.shift_on, ifa.caps_on, ifa.overflow, ifa.key_count}, exp_v);
      else n_pass++;
      hd = (mq[1].size() != 0) ? mq[1][0] : 8'h00;
      exp_v = {mq[1].size() != 0, hd, m_ls | m_rs, m_caps, m_ovf[1], m_cnt[1]};
      n_checks++;
      if ({ifb.out_valid, ifb.out_data, ifb.shift_on, ifb.caps_on, ifb.overflow, ifb.key_count} !== exp_v)
        $display("FAIL rand_b cyc %0d got %h exp %h", cyc,
          {ifb.out_valid, ifb.out_data, ifb.shift_on, ifb.caps_on, ifb.overflow, ifb.key_count}, exp_v);
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    test_reset();
    test_letter();
    test_shift();
    test_caps();
    test_repeat();
    test_extended();
    test_reset_midseq();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
